// File: rtl/wb_single_initiator_switch_pkg.sv
// Shared types and constants for the single-initiator Wishbone switch.
package wb_single_initiator_switch_pkg;

  localparam int unsigned NUM_TARGETS = 4;
  localparam int unsigned IDX_W       = $clog2(NUM_TARGETS);
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TARGET   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_e;

endpackage

// File: rtl/wb_switch_addr_decoder.sv
// Address-prefix decoder: picks the lowest-numbered target whose prefix matches.
module wb_switch_addr_decoder
  import wb_single_initiator_switch_pkg::*;
#(
  parameter int unsigned           ADDR_DEC_W = 8,
  parameter logic [ADDR_DEC_W-1:0] T0_ADDR    = ADDR_DEC_W'(8'h00),
  parameter logic [ADDR_DEC_W-1:0] T1_ADDR    = ADDR_DEC_W'(8'h04),
  parameter logic [ADDR_DEC_W-1:0] T2_ADDR    = ADDR_DEC_W'(8'h90),
  parameter logic [ADDR_DEC_W-1:0] T3_ADDR    = ADDR_DEC_W'(8'h9e)
) (
  input  logic [ADDR_DEC_W-1:0] prefix_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      index_o
);

  logic [ADDR_DEC_W-1:0] tgt_addr [NUM_TARGETS];

  assign tgt_addr[0] = T0_ADDR;
  assign tgt_addr[1] = T1_ADDR;
  assign tgt_addr[2] = T2_ADDR;
  assign tgt_addr[3] = T3_ADDR;

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int k = int'(NUM_TARGETS) - 1; k >= 0; k--) begin
      if (prefix_i == tgt_addr[k]) begin
        hit_o   = 1'b1;
        index_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_single_initiator_switch.sv
// One Wishbone initiator to four targets: prefix decode, per-target strobe,
// response mux, unmapped/target/timeout error termination.
module wb_single_initiator_switch
  import wb_single_initiator_switch_pkg::*;
#(
  parameter int unsigned           ADDR_DEC_W     = 8,
  parameter logic [ADDR_DEC_W-1:0] T0_ADDR        = ADDR_DEC_W'(8'h00),
  parameter logic [ADDR_DEC_W-1:0] T1_ADDR        = ADDR_DEC_W'(8'h04),
  parameter logic [ADDR_DEC_W-1:0] T2_ADDR        = ADDR_DEC_W'(8'h90),
  parameter logic [ADDR_DEC_W-1:0] T3_ADDR        = ADDR_DEC_W'(8'h9e),
  parameter int unsigned           TIMEOUT_CYCLES = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          i_wb_cyc_i,
  input  logic                          i_wb_stb_i,
  input  logic                          i_wb_we_i,
  input  logic [31:0]                   i_wb_adr_i,
  input  logic [3:0]                    i_wb_sel_i,
  input  logic [DATA_W-1:0]             i_wb_dat_i,
  output logic [DATA_W-1:0]             i_wb_dat_o,
  output logic                          i_wb_ack_o,
  output logic                          i_wb_err_o,
  output logic [NUM_TARGETS-1:0]        t_wb_cyc_o,
  output logic [NUM_TARGETS-1:0]        t_wb_stb_o,
  output logic [31:0]                   t_wb_adr_o,
  output logic [3:0]                    t_wb_sel_o,
  output logic                          t_wb_we_o,
  output logic [DATA_W-1:0]             t_wb_dat_o,
  input  logic [NUM_TARGETS*DATA_W-1:0] t_wb_dat_i,
  input  logic [NUM_TARGETS-1:0]        t_wb_ack_i,
  input  logic [NUM_TARGETS-1:0]        t_wb_err_i,
  output logic [1:0]                    err_cause_o
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_cause_e       err_cause_q, err_cause_d;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              sel_ack;
  logic              sel_err;
  logic [DATA_W-1:0] sel_dat;

  wb_switch_addr_decoder #(
    .ADDR_DEC_W (ADDR_DEC_W),
    .T0_ADDR    (T0_ADDR),
    .T1_ADDR    (T1_ADDR),
    .T2_ADDR    (T2_ADDR),
    .T3_ADDR    (T3_ADDR)
  ) u_dec (
    .prefix_i (i_wb_adr_i[31 -: ADDR_DEC_W]),
    .hit_o    (dec_hit),
    .index_o  (dec_idx)
  );

  assign sel_ack = t_wb_ack_i[sel_q];
  assign sel_err = t_wb_err_i[sel_q];
  assign sel_dat = t_wb_dat_i[{sel_q, 5'b0} +: DATA_W];

  assign t_wb_adr_o = i_wb_adr_i;
  assign t_wb_sel_o = i_wb_sel_i;
  assign t_wb_we_o  = i_wb_we_i;
  assign t_wb_dat_o = i_wb_dat_i;

  assign t_wb_cyc_o  = (state_q == ST_ACCESS) ? (NUM_TARGETS'(1) << sel_q) : '0;
  assign t_wb_stb_o  = t_wb_cyc_o;
  assign err_cause_o = err_cause_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      err_cause_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      err_cause_q <= err_cause_d;
    end
  end

  // Next state and initiator-side termination; a dropped cyc suppresses both.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    err_cause_d = err_cause_q;
    i_wb_ack_o  = 1'b0;
    i_wb_err_o  = 1'b0;
    i_wb_dat_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc_i && i_wb_stb_i) begin
          if (dec_hit) begin
            state_d = ST_ACCESS;
            sel_d   = dec_idx;
            cnt_d   = '0;
          end else begin
            state_d     = ST_ERR;
            err_cause_d = ERR_UNMAPPED;
          end
        end
      end
      ST_ACCESS: begin
        i_wb_dat_o = sel_dat;
        if (!i_wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_err) begin
          i_wb_err_o  = 1'b1;
          err_cause_d = ERR_TARGET;
          state_d     = ST_IDLE;
        end else if (sel_ack) begin
          i_wb_ack_o = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d     = ST_ERR;
          err_cause_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        i_wb_err_o = i_wb_cyc_i;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_single_initiator_switch.sv
// Self-checking bench for wb_single_initiator_switch (TIMEOUT_CYCLES=4).
module tb_wb_single_initiator_switch;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_cyc, i_stb, i_we;
  logic [31:0]  i_adr;
  logic [3:0]   i_sel;
  logic [31:0]  i_dat;
  logic [31:0]  o_dat;
  logic         o_ack, o_err;
  logic [3:0]   t_cyc, t_stb;
  logic [31:0]  t_adr;
  logic [3:0]   t_sel;
  logic         t_we;
  logic [31:0]  t_wdat;
  logic [127:0] t_rdat;
  logic [3:0]   t_ack, t_err;
  logic [1:0]   cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_single_initiator_switch #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .i_wb_cyc_i  (i_cyc),
    .i_wb_stb_i  (i_stb),
    .i_wb_we_i   (i_we),
    .i_wb_adr_i  (i_adr),
    .i_wb_sel_i  (i_sel),
    .i_wb_dat_i  (i_dat),
    .i_wb_dat_o  (o_dat),
    .i_wb_ack_o  (o_ack),
    .i_wb_err_o  (o_err),
    .t_wb_cyc_o  (t_cyc),
    .t_wb_stb_o  (t_stb),
    .t_wb_adr_o  (t_adr),
    .t_wb_sel_o  (t_sel),
    .t_wb_we_o   (t_we),
    .t_wb_dat_o  (t_wdat),
    .t_wb_dat_i  (t_rdat),
    .t_wb_ack_i  (t_ack),
    .t_wb_err_i  (t_err),
    .err_cause_o (cause)
  );

  // rsp: 0 silent, 1 ack, 2 err, 3 ack+err; dly: stb cycles seen before the response
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          rsp;
    int          dly;
    logic [31:0] rdat;
    logic [3:0]  exp_stb;
    logic        exp_ack;
    logic        exp_err;
    int          exp_term;
    int          exp_nstb;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs [9];
  vec_t sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (o_ack && o_err) begin
        n_fail++;
        $display("FAIL ack_err_exclusive: got ack=%b err=%b expected not both", o_ack, o_err);
      end
    end
  end

  task automatic idle_bus();
    i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
    i_adr = '0; i_sel = '0; i_dat = '0;
    t_ack = '0; t_err = '0; t_rdat = '0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int          k, noise, nstb, first, term;
    logic        mask_ok, bcast_ok, ack_s, err_s;
    logic [31:0] dat_s;
    k = -1;
    for (int i = 0; i < 4; i++) if (v.exp_stb[i]) k = i;
    noise = (k < 0) ? 1 : (k + 1) % 4;
    @(posedge clk); #1;
    i_cyc = 1'b1; i_stb = 1'b1; i_we = v.we;
    i_adr = v.adr; i_sel = v.sel; i_dat = v.wdat;
    for (int i = 0; i < 4; i++) t_rdat[32*i +: 32] = (i == k) ? v.rdat : (~v.rdat ^ 32'(i));
    t_ack[noise] = 1'b1;
    t_err[noise] = 1'b1;
    sb_q.push_back(v);
    nstb = 0; first = -1; term = -1; mask_ok = 1'b1; bcast_ok = 1'b1;
    ack_s = 1'b0; err_s = 1'b0; dat_s = '0;
    for (int c = 0; c < 20 && term < 0; c++) begin
      @(negedge clk);
      if (t_stb != 4'b0 || t_cyc != 4'b0) begin
        if (first < 0) first = c;
        nstb++;
        if (t_stb !== v.exp_stb || t_cyc !== v.exp_stb) mask_ok = 1'b0;
        if (t_adr !== v.adr || t_we !== v.we || t_sel !== v.sel || t_wdat !== v.wdat) bcast_ok = 1'b0;
      end
      if (o_ack || o_err) begin
        term = c; ack_s = o_ack; err_s = o_err; dat_s = o_dat;
      end else begin
        @(posedge clk); #1;
        if (k >= 0 && v.rsp != 0 && nstb == v.dly) begin
          t_ack[k] = (v.rsp == 1 || v.rsp == 3);
          t_err[k] = (v.rsp >= 2);
        end
      end
    end
    e = sb_q.pop_front();
    check($sformatf("v%0d term_cycle", idx), 32'(term), 32'(e.exp_term));
    check($sformatf("v%0d ack", idx), 32'(ack_s), 32'(e.exp_ack));
    check($sformatf("v%0d err", idx), 32'(err_s), 32'(e.exp_err));
    if (e.exp_ack) check($sformatf("v%0d rdata", idx), dat_s, e.rdat);
    check($sformatf("v%0d stb_cycles", idx), 32'(nstb), 32'(e.exp_nstb));
    if (e.exp_nstb > 0) begin
      check($sformatf("v%0d stb_latency", idx), 32'(first), 32'd1);
      check($sformatf("v%0d stb_mask", idx), 32'(mask_ok), 32'd1);
      check($sformatf("v%0d broadcast", idx), 32'(bcast_ok), 32'd1);
    end
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check($sformatf("v%0d err_cause", idx), 32'(cause), 32'(e.exp_cause));
    check($sformatf("v%0d stb_after", idx), 32'(t_stb), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //           adr           we    sel    wdat          rsp dly rdat          stb     ack   err  term nstb cause
    vecs[0] = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,         1, 1, 32'hDEAD_BEEF, 4'b0001, 1'b1, 1'b0, 2, 2, 2'd0};
    vecs[1] = '{32'h9000_0000, 1'b1, 4'hF, 32'h1234_5678, 1, 1, 32'h0000_0000, 4'b0100, 1'b1, 1'b0, 2, 2, 2'd0};
    vecs[2] = '{32'h5000_0000, 1'b0, 4'hF, 32'h0,         0, 1, 32'h0,         4'b0000, 1'b0, 1'b1, 1, 0, 2'd1};
    vecs[3] = '{32'h0400_0020, 1'b0, 4'h3, 32'h0,         1, 3, 32'hCAFE_F00D, 4'b0010, 1'b1, 1'b0, 4, 4, 2'd1};
    vecs[4] = '{32'h9E00_0004, 1'b0, 4'hF, 32'h0,         3, 1, 32'h1111_2222, 4'b1000, 1'b0, 1'b1, 2, 2, 2'd2};
    vecs[5] = '{32'h04FF_FFFC, 1'b0, 4'hF, 32'h0,         0, 1, 32'h3333_4444, 4'b0010, 1'b0, 1'b1, 5, 4, 2'd3};
    vecs[6] = '{32'h9E12_3456, 1'b1, 4'hC, 32'hA5A5_5A5A, 1, 2, 32'h0BAD_C0DE, 4'b1000, 1'b1, 1'b0, 3, 3, 2'd3};
    vecs[7] = '{32'h9000_0040, 1'b0, 4'hF, 32'h0,         2, 2, 32'h7777_8888, 4'b0100, 1'b0, 1'b1, 3, 3, 2'd2};
    vecs[8] = '{32'h0100_0000, 1'b0, 4'hF, 32'h0,         0, 1, 32'h0,         4'b0000, 1'b0, 1'b1, 1, 0, 2'd1};

    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stb", 32'(t_stb), 32'd0);
    check("reset cyc", 32'(t_cyc), 32'd0);
    check("reset ack_err", 32'({o_ack, o_err}), 32'd0);
    check("reset dat", o_dat, 32'd0);
    check("reset cause", 32'(cause), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Abort: cyc drops while the selected target acks in the same cycle.
    @(posedge clk); #1;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h0000_0100; i_sel = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort stb", 32'(t_stb), 32'b0001);
    @(posedge clk); #1;
    i_cyc = 1'b0; i_stb = 1'b0; t_ack[0] = 1'b1;
    @(negedge clk);
    check("abort ack", 32'(o_ack), 32'd0);
    check("abort err", 32'(o_err), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("abort stb_after", 32'(t_stb), 32'd0);
    check("abort cause", 32'(cause), 32'd1);

    // Reset pulse in the middle of an access to target 2.
    @(posedge clk); #1;
    i_cyc = 1'b1; i_stb = 1'b1; i_adr = 32'h9000_0000; i_sel = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid stb_before", 32'(t_stb), 32'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();
    @(negedge clk);
    check("rst_mid stb", 32'(t_stb), 32'd0);
    check("rst_mid cyc", 32'(t_cyc), 32'd0);
    check("rst_mid cause", 32'(cause), 32'd0);
    run_vec(10, vecs[1]);

    // Timeout again, then a late ack from the silent target with cyc still held.
    run_vec(11, vecs[5]);
    @(posedge clk); #1;
    i_cyc = 1'b1; i_stb = 1'b0; i_adr = 32'h0400_0000; t_ack[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("late_ack ack c%0d", c), 32'(o_ack), 32'd0);
      check($sformatf("late_ack stb c%0d", c), 32'(t_stb), 32'd0);
      @(posedge clk); #1;
    end
    idle_bus();
    @(negedge clk);
    check("late_ack cause", 32'(cause), 32'd3);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_single_initiator_switch.md
WB_SINGLE_INITIATOR_SWITCH -- requirements
Module: wb_single_initiator_switch

Interface
REQ-001 SHALL have parameter ADDR_DEC_W, default 8: number of address MSBs (adr[31:32-ADDR_DEC_W]) compared for decode.
REQ-002 SHALL have parameters T0_ADDR..T3_ADDR, defaults 8'h00, 8'h04, 8'h90, 8'h9e: decode prefix of targets 0..3.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..255: maximum cycles an access waits in ACCESS for target ack/err.
REQ-004 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 i_wb_cyc_i, i_wb_stb_i, i_wb_we_i  in  1 each  initiator cycle, strobe, write enable.
REQ-007 i_wb_adr_i  in  32  initiator address; i_wb_sel_i  in  4  byte selects; i_wb_dat_i  in  32  write data.
REQ-008 i_wb_dat_o  out  32  read data; i_wb_ack_o, i_wb_err_o  out  1 each  termination to initiator.
REQ-009 t_wb_cyc_o, t_wb_stb_o  out  4 each  per-target cycle/strobe, bit k = target k.
REQ-010 t_wb_adr_o  out  32, t_wb_sel_o  out  4, t_wb_we_o  out  1, t_wb_dat_o  out  32: initiator signals broadcast to all targets unchanged.
REQ-011 t_wb_dat_i  in  128  target read data, bits [32k+31:32k] = target k; t_wb_ack_i, t_wb_err_i  in  4 each.
REQ-012 err_cause_o  out  2  cause of last error termination: 0 none, 1 unmapped, 2 target err, 3 timeout.

Function
REQ-013 States: IDLE, ACCESS, ERR; state, selected index sel_q[1:0], timeout counter cnt[7:0] and err_cause_o SHALL be registers.
REQ-014 IDLE with i_wb_cyc_i&i_wb_stb_i: prefix matches target k (lowest k wins on duplicate prefixes) -> ACCESS, sel_q<=k, cnt<=0; no match -> ERR, err_cause_o<=1.
REQ-015 t_wb_cyc_o[k] and t_wb_stb_o[k] SHALL be 1 exactly while state==ACCESS and sel_q==k; all other bits 0.
REQ-016 In ACCESS, i_wb_ack_o = t_wb_ack_i[sel_q] & ~t_wb_err_i[sel_q], combinational; i_wb_dat_o = t_wb_dat_i slice sel_q; else i_wb_dat_o = 0.
REQ-017 In ACCESS, t_wb_err_i[sel_q] SHALL give i_wb_err_o=1 same cycle, err_cause_o<=2, next state IDLE; err wins over simultaneous ack.
REQ-018 In ACCESS, ack SHALL return state to IDLE next cycle; err_cause_o unchanged.
REQ-019 In ACCESS without ack/err, cnt SHALL increment; when cnt==TIMEOUT_CYCLES-1 -> ERR, err_cause_o<=3; ack/err arriving on that same cycle wins and timeout does not occur.
REQ-020 ERR SHALL assert i_wb_err_o for exactly one cycle, then return to IDLE.
REQ-021 i_wb_cyc_i low in ACCESS or ERR (abort) SHALL return to IDLE next cycle with no ack/err to initiator.
REQ-022 Acks/errs from non-selected targets, or any target in IDLE, SHALL be ignored.
REQ-023 Latency: target sees stb one cycle after initiator stb; back-to-back accesses incur one IDLE bubble cycle.
REQ-024 i_wb_ack_o and i_wb_err_o SHALL never be high in the same cycle.

Reset
REQ-025 wb_rst_i high at a clock edge SHALL force state IDLE, sel_q 0, cnt 0, err_cause_o 0; all t_wb_cyc_o/t_wb_stb_o, i_wb_ack_o, i_wb_err_o 0 from next cycle, including mid-access.
REQ-026 Reset SHALL take priority over every other transition.

Structure
REQ-027 Shared package SHALL hold the state enumeration, NUM_TARGETS=4 and err_cause codes.
REQ-028 Prefix comparison SHALL be one combinational sub-module wb_switch_addr_decoder (outputs hit, index); FSM, counter and muxing stay in top.

Verification
REQ-029 Read 0x0000_0010, target 0 acks 1 cycle after its stb with 0xDEADBEEF -> t_wb_stb_o=4'b0001 one cycle after stb, i_wb_dat_o=0xDEADBEEF with i_wb_ack_o.
REQ-030 Write 0x9000_0000 sel 4'hF -> only t_wb_stb_o[2] high; ack forwarded; t_wb_dat_o equals i_wb_dat_i.
REQ-031 Access 0x5000_0000 -> no target strobed; i_wb_err_o one cycle, 1 cycle after stb; err_cause_o=1.
REQ-032 TIMEOUT_CYCLES=4, target 1 silent -> t_wb_stb_o[1] high 4 cycles, then i_wb_err_o one cycle; err_cause_o=3; late target ack ignored.
REQ-033 Target 3 asserts ack and err same cycle -> i_wb_err_o=1, i_wb_ack_o=0, err_cause_o=2.
REQ-034 wb_rst_i pulsed during ACCESS -> t_wb_cyc_o=0 next cycle, err_cause_o=0, next access decodes normally.
